// File: rtl/bram_port_arbiter.sv
// Round-robin arbiter sharing one 18K BRAM port among NREQ requesters.
// Optional macro BRAM_ARB_OUTREG_EN registers the read response (3-cycle latency).
module bram_port_arbiter #(
  parameter int NREQ = 4,
  parameter int ABITS = 14,
  parameter int DBITS = 18,
  parameter int BEBITS = 2,
  parameter logic [DBITS-1:0] CLEAR_DATA = '0
) (
  input  logic                    CLK_i,
  input  logic                    RST_N_i,
  input  logic [NREQ-1:0]         REQ_VALID_i,
  input  logic [NREQ-1:0]         REQ_WE_i,
  input  logic [NREQ*ABITS-1:0]   REQ_ADDR_i,
  input  logic [NREQ*DBITS-1:0]   REQ_WDATA_i,
  input  logic [NREQ*BEBITS-1:0]  REQ_BE_i,
  output logic [NREQ-1:0]         REQ_READY_o,
  output logic [NREQ-1:0]         RSP_VALID_o,
  output logic [DBITS-1:0]        RSP_RDATA_o,
  input  logic                    CLEAR_START_i,
  output logic                    CLEAR_BUSY_o,
  output logic                    CLEAR_DONE_o,
  output logic [ABITS-1:0]        BRAM_ADDR_o,
  output logic [DBITS-1:0]        BRAM_WDATA_o,
  output logic [BEBITS-1:0]       BRAM_BE_o,
  output logic                    BRAM_REN_o,
  output logic                    BRAM_WEN_o,
  input  logic [DBITS-1:0]        BRAM_RDATA_i
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t            state;
  logic [PW-1:0]     pri;
  logic [PW-1:0]     gidx;
  logic [PW:0]       sum;
  logic              found;
  logic [NREQ-1:0]   grant;
  logic [2*NREQ-1:0] vv;
  logic [NREQ-1:0]   rot;
  logic [NREQ-1:0]   tag1;
  logic [NREQ-1:0]   tag2;
  logic [ABITS-1:0]  cnt;
  logic [ABITS-1:0]  sel_addr;
  logic [DBITS-1:0]  sel_wdata;
  logic [BEBITS-1:0] sel_be;
  logic              sel_we;

  // Rotate valids so bit 0 is the requester at the priority pointer.
  always_comb begin
    vv    = {REQ_VALID_i, REQ_VALID_i} >> pri;
    rot   = vv[NREQ-1:0];
    grant = '0;
    gidx  = '0;
    sum   = '0;
    found = 1'b0;
    if (state == IDLE && !CLEAR_START_i) begin
      for (int k = 0; k < NREQ; k++) begin
        if (!found && rot[k]) begin
          found = 1'b1;
          sum   = {1'b0, pri} + (PW+1)'(k);
          if (sum >= (PW+1)'(NREQ))
            sum = sum - (PW+1)'(NREQ);
          gidx  = sum[PW-1:0];
        end
      end
      if (found)
        grant[gidx] = 1'b1;
    end
  end

  assign REQ_READY_o = grant;

  always_comb begin
    sel_addr  = '0;
    sel_wdata = '0;
    sel_be    = '0;
    sel_we    = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      if (grant[k]) begin
        sel_addr  = REQ_ADDR_i[k*ABITS +: ABITS];
        sel_wdata = REQ_WDATA_i[k*DBITS +: DBITS];
        sel_be    = REQ_BE_i[k*BEBITS +: BEBITS];
        sel_we    = REQ_WE_i[k];
      end
    end
  end

  always_ff @(posedge CLK_i or negedge RST_N_i) begin
    if (!RST_N_i) begin
      state        <= IDLE;
      pri          <= '0;
      cnt          <= '0;
      tag1         <= '0;
      tag2         <= '0;
      BRAM_ADDR_o  <= '0;
      BRAM_WDATA_o <= '0;
      BRAM_BE_o    <= '0;
      BRAM_REN_o   <= 1'b0;
      BRAM_WEN_o   <= 1'b0;
      CLEAR_BUSY_o <= 1'b0;
      CLEAR_DONE_o <= 1'b0;
    end else begin
      BRAM_REN_o   <= 1'b0;
      BRAM_WEN_o   <= 1'b0;
      CLEAR_DONE_o <= 1'b0;
      tag1         <= '0;
      tag2         <= tag1;
      unique case (state)
        IDLE: begin
          if (CLEAR_START_i) begin
            state        <= CLEAR;
            CLEAR_BUSY_o <= 1'b1;
            BRAM_WEN_o   <= 1'b1;
            BRAM_ADDR_o  <= '0;
            BRAM_WDATA_o <= CLEAR_DATA;
            BRAM_BE_o    <= '1;
            cnt          <= ABITS'(1);
          end else if (found) begin
            pri          <= (gidx == PW'(NREQ-1)) ? '0 : gidx + 1'b1;
            BRAM_ADDR_o  <= sel_addr;
            BRAM_WDATA_o <= sel_wdata;
            BRAM_BE_o    <= sel_be;
            BRAM_REN_o   <= ~sel_we;
            BRAM_WEN_o   <= sel_we;
            tag1         <= sel_we ? '0 : grant;
          end
        end
        CLEAR: begin
          // Leave once the last-address write has been on the port.
          if (CLEAR_DONE_o) begin
            state        <= IDLE;
            CLEAR_BUSY_o <= 1'b0;
            cnt          <= '0;
          end else begin
            BRAM_WEN_o   <= 1'b1;
            BRAM_ADDR_o  <= cnt;
            BRAM_WDATA_o <= CLEAR_DATA;
            BRAM_BE_o    <= '1;
            cnt          <= cnt + 1'b1;
            CLEAR_DONE_o <= (cnt == '1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef BRAM_ARB_OUTREG_EN
  logic [NREQ-1:0]  tag3;
  logic [DBITS-1:0] rdata_q;

  always_ff @(posedge CLK_i or negedge RST_N_i) begin
    if (!RST_N_i) begin
      tag3    <= '0;
      rdata_q <= '0;
    end else begin
      tag3    <= tag2;
      rdata_q <= BRAM_RDATA_i;
    end
  end

  assign RSP_VALID_o = tag3;
  assign RSP_RDATA_o = rdata_q;
`else
  assign RSP_VALID_o = tag2;
  assign RSP_RDATA_o = BRAM_RDATA_i;
`endif

endmodule
